macarray_ctrl: RTL and testbench

- Sequencing controller for the 4x4 MAC array datapath. It owns all buffer-memory control, for matrix sizes up to 8x8x8.
- Latches MNT on START, then walks output tiles (mt, tt) in row-major order.
- For each tile it clears the array, streams N operand rows from input/weight memories, waits out the systolic drain, and writes the tile's result rows to output memory.
- Sits between the top-level START/MNT interface and the MAC array plus the three buffer memories.

---
 rtl/macarray_pkg.sv | 34 +++
 rtl/macarray_tile_cnt.sv | 69 ++++++
 rtl/macarray_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_macarray_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/macarray_pkg.sv
// Shared types, sizes and helpers for the MAC array sequencing controller.
package macarray_pkg;

    localparam int ARR_DIM   = 4;
    localparam int MAX_DIM   = 8;
    localparam int DRAIN_CYC = 2 * (ARR_DIM - 1);

    localparam int FLD_W = 4;
    localparam int M_LSB = 8;
    localparam int N_LSB = 4;
    localparam int T_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_e;

    // Number of ARR_DIM-wide tiles needed to cover dim (1 or 2 for legal sizes).
    function automatic logic [1:0] ceil_tiles(input logic [FLD_W-1:0] dim);
        logic [FLD_W:0] sum;
        sum = {1'b0, dim} + 5'(ARR_DIM - 1);
        return 2'(sum >> 2);
    endfunction

    function automatic logic dim_legal(input logic [FLD_W-1:0] dim);
        return (dim != '0) && (dim <= 4'(MAX_DIM));
    endfunction

endpackage

// File: rtl/macarray_tile_cnt.sv
// Output-tile iterator: walks (mt, tt) row-major and derives the column mask
// and last valid result row for the current tile.
module macarray_tile_cnt
    import macarray_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               advance,
    input  logic [FLD_W-1:0]   m,
    input  logic [FLD_W-1:0]   t,
    output logic               mt,
    output logic               tt,
    output logic               last_tile,
    output logic [ARR_DIM-1:0] col_mask,
    output logic [1:0]         last_row
);

    logic             mt_q, mt_d;
    logic             tt_q, tt_d;
    logic [1:0]       mt_tiles, tt_tiles;
    logic             last_mt, last_tt;
    logic [FLD_W-1:0] rows_left;

    assign mt_tiles  = ceil_tiles(m);
    assign tt_tiles  = ceil_tiles(t);
    assign last_mt   = ({1'b0, mt_q} == (mt_tiles - 2'd1));
    assign last_tt   = ({1'b0, tt_q} == (tt_tiles - 2'd1));
    assign last_tile = last_mt && last_tt;

    always_comb begin
        mt_d = mt_q;
        tt_d = tt_q;
        if (init) begin
            mt_d = 1'b0;
            tt_d = 1'b0;
        end else if (advance) begin
            if (last_tt) begin
                tt_d = 1'b0;
                mt_d = mt_q + 1'b1;
            end else begin
                tt_d = tt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mt_q <= 1'b0;
            tt_q <= 1'b0;
        end else begin
            mt_q <= mt_d;
            tt_q <= tt_d;
        end
    end

    // Lane c holds output column tt*ARR_DIM + c.
    for (genvar gi = 0; gi < ARR_DIM; gi++) begin : g_col
        assign col_mask[gi] = ({1'b0, tt_q, 2'(gi)} < t);
    end

    assign rows_left = m - {1'b0, mt_q, 2'b00};
    assign last_row  = (rows_left >= 4'(ARR_DIM)) ? 2'(ARR_DIM - 1)
                                                  : 2'(rows_left - 4'd1);

    assign mt = mt_q;
    assign tt = tt_q;

endmodule

// File: rtl/macarray_ctrl.sv
// Sequencing controller for the 4x4 MAC array: per output tile it clears,
// feeds N operand rows, drains the systolic pipe and writes result rows.
module macarray_ctrl
    import macarray_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] MNT,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        EN_I,
    output logic [2:0]  ADDR_I,
    output logic        EN_W,
    output logic [2:0]  ADDR_W,
    output logic        EN_O,
    output logic        RW_O,
    output logic [3:0]  ADDR_O,
    output logic        ARR_CLR,
    output logic        ARR_VALID,
    output logic        SEL_M,
    output logic        SEL_T,
    output logic [1:0]  ROW_SEL,
    output logic [3:0]  COL_MASK
);

    state_e           state_q, state_d;
    logic [2:0]       k_q, k_d;
    logic [2:0]       drain_q, drain_d;
    logic [1:0]       row_q, row_d;
    logic [FLD_W-1:0] m_q, m_d, n_q, n_d, t_q, t_d;

    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             feed_q, feed_d, arr_valid_q, arr_valid_d, arr_clr_q, arr_clr_d;
    logic [2:0]       addr_k_q, addr_k_d;
    logic             sel_m_q, sel_m_d, sel_t_q, sel_t_d;
    logic             wr_q, wr_d;
    logic [3:0]       addr_o_q, addr_o_d, col_mask_q, col_mask_d;
    logic [1:0]       row_sel_q, row_sel_d;

    logic             mnt_legal, tile_init, tile_adv;
    logic             tile_mt, tile_tt, tile_last;
    logic [3:0]       tile_col_mask;
    logic [1:0]       tile_last_row;

    assign mnt_legal = dim_legal(MNT[M_LSB +: FLD_W]) && dim_legal(MNT[N_LSB +: FLD_W])
                    && dim_legal(MNT[T_LSB +: FLD_W]);

    macarray_tile_cnt u_tile_cnt (
        .clk       (CLK),
        .rst       (RST),
        .init      (tile_init),
        .advance   (tile_adv),
        .m         (m_q),
        .t         (t_q),
        .mt        (tile_mt),
        .tt        (tile_tt),
        .last_tile (tile_last),
        .col_mask  (tile_col_mask),
        .last_row  (tile_last_row)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        drain_d   = drain_q;
        row_d     = row_q;
        m_d       = m_q;
        n_d       = n_q;
        t_d       = t_q;
        err_d     = 1'b0;
        tile_init = 1'b0;
        tile_adv  = 1'b0;
        unique case (state_q)
            S_IDLE: if (START) begin
                if (mnt_legal) begin
                    m_d       = MNT[M_LSB +: FLD_W];
                    n_d       = MNT[N_LSB +: FLD_W];
                    t_d       = MNT[T_LSB +: FLD_W];
                    tile_init = 1'b1;
                    state_d   = S_CLEAR;
                end else begin
                    err_d = 1'b1;
                end
            end
            S_CLEAR: begin
                k_d     = '0;
                state_d = S_FEED;
            end
            S_FEED: if ({1'b0, k_q} == (n_q - 4'd1)) begin
                drain_d = '0;
                state_d = S_DRAIN;
            end else begin
                k_d = k_q + 3'd1;
            end
            S_DRAIN: if (drain_q == 3'(DRAIN_CYC - 1)) begin
                row_d   = '0;
                state_d = S_WRITE;
            end else begin
                drain_d = drain_q + 3'd1;
            end
            S_WRITE: if (row_q == tile_last_row) begin
                state_d = S_NEXT;
            end else begin
                row_d = row_q + 2'd1;
            end
            S_NEXT: if (tile_last) begin
                state_d = S_DONE;
            end else begin
                tile_adv = 1'b1;
                state_d  = S_CLEAR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        feed_d      = (state_d == S_FEED);
        wr_d        = (state_d == S_WRITE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        arr_clr_d   = (state_d == S_CLEAR);
        arr_valid_d = feed_q;
        addr_k_d    = feed_d ? k_d : '0;
        sel_m_d     = feed_d & tile_mt;
        sel_t_d     = feed_d & tile_tt;
        row_sel_d   = wr_d ? row_d : '0;
        addr_o_d    = wr_d ? {tile_mt, row_d, tile_tt} : '0;
        col_mask_d  = wr_d ? tile_col_mask : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            drain_q     <= '0;
            row_q       <= '0;
            m_q         <= '0;
            n_q         <= '0;
            t_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            feed_q      <= 1'b0;
            arr_valid_q <= 1'b0;
            arr_clr_q   <= 1'b0;
            addr_k_q    <= '0;
            sel_m_q     <= 1'b0;
            sel_t_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_o_q    <= '0;
            col_mask_q  <= '0;
            row_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            row_q       <= row_d;
            m_q         <= m_d;
            n_q         <= n_d;
            t_q         <= t_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            feed_q      <= feed_d;
            arr_valid_q <= arr_valid_d;
            arr_clr_q   <= arr_clr_d;
            addr_k_q    <= addr_k_d;
            sel_m_q     <= sel_m_d;
            sel_t_q     <= sel_t_d;
            wr_q        <= wr_d;
            addr_o_q    <= addr_o_d;
            col_mask_q  <= col_mask_d;
            row_sel_q   <= row_sel_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign EN_I      = feed_q;
    assign EN_W      = feed_q;
    assign ADDR_I    = addr_k_q;
    assign ADDR_W    = addr_k_q;
    assign EN_O      = wr_q;
    assign RW_O      = wr_q;
    assign ADDR_O    = addr_o_q;
    assign ARR_CLR   = arr_clr_q;
    assign ARR_VALID = arr_valid_q;
    assign SEL_M     = sel_m_q;
    assign SEL_T     = sel_t_q;
    assign ROW_SEL   = row_sel_q;
    assign COL_MASK  = col_mask_q;

endmodule

// File: tb/tb_macarray_ctrl.sv
// Randomized self-checking bench for macarray_ctrl against a tile-level
// model of the expected memory reads, result writes and job length.
module tb_macarray_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mnt = '0;
    logic        start = 1'b0;
    logic        busy, done, err, en_i, en_w, en_o, rw_o;
    logic        arr_clr, arr_valid, sel_m, sel_t;
    logic [2:0]  addr_i, addr_w;
    logic [3:0]  addr_o, col_mask;
    logic [1:0]  row_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    macarray_ctrl dut (
        .CLK       (clk),
        .RST       (rst),
        .MNT       (mnt),
        .START     (start),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err),
        .EN_I      (en_i),
        .ADDR_I    (addr_i),
        .EN_W      (en_w),
        .ADDR_W    (addr_w),
        .EN_O      (en_o),
        .RW_O      (rw_o),
        .ADDR_O    (addr_o),
        .ARR_CLR   (arr_clr),
        .ARR_VALID (arr_valid),
        .SEL_M     (sel_m),
        .SEL_T     (sel_t),
        .ROW_SEL   (row_sel),
        .COL_MASK  (col_mask)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, done, err, en_i, en_w, en_o, rw_o, arr_clr, arr_valid,
                    sel_m, sel_t, addr_i, addr_w, addr_o, col_mask, row_sel});
    endfunction

    // Runs one legal job from the current negedge. noise != 0 re-pulses START
    // mid-job; abort_at > 0 asserts RST at that cycle; start_at_done raises
    // START with MNT=0x111 during the DONE cycle.
    task automatic run_job(input logic [11:0] job, input logic [11:0] noise,
                           input int abort_at, input bit start_at_done);
        int m, n, t, rows, total, tiles, clr_cnt, cyc, mask, exp_v;
        bit prev_en_i, seen_done, quiet_bad;
        int rd_q[$];
        int wr_q[$];
        m = int'(job[11:8]);
        n = int'(job[7:4]);
        t = int'(job[3:0]);
        total = 0;
        tiles = ((m + 3) / 4) * ((t + 3) / 4);
        for (int mt = 0; mt < (m + 3) / 4; mt++) begin
            for (int tt = 0; tt < (t + 3) / 4; tt++) begin
                rows = (m - mt * 4 > 4) ? 4 : m - mt * 4;
                total += 1 + n + 6 + rows + 1;
                for (int k = 0; k < n; k++) rd_q.push_back(k * 4 + mt * 2 + tt);
                mask = 0;
                for (int c = 0; c < 4; c++) if (tt * 4 + c < t) mask |= (1 << c);
                for (int r = 0; r < rows; r++)
                    wr_q.push_back((((mt * 4 + r) * 2 + tt) << 8) | (mask << 4) | r);
            end
        end

        mnt = job;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mnt = 12'($urandom);
        prev_en_i = 1'b0;
        clr_cnt = 0;
        seen_done = 1'b0;
        for (cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            if (cyc == 0) check("busy_rise", busy, 1);
            if (abort_at > 0 && cyc == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_outs", all_outs(), 0);
                @(negedge clk);
                rst = 1'b0;
                quiet_bad = 1'b0;
                repeat (30) begin
                    @(negedge clk);
                    quiet_bad |= done | busy | en_i | en_o;
                end
                check("abort_quiet", quiet_bad, 0);
                $display("job mnt=%03h aborted at cycle %0d", job, cyc);
                return;
            end
            check("arr_valid", arr_valid, prev_en_i);
            if (en_i || en_w) begin
                if (rd_q.size() == 0) check("rd_extra", 1, 0);
                else begin
                    exp_v = rd_q.pop_front();
                    check("rd", {en_i, en_w, addr_i, addr_w, sel_m, sel_t},
                          {2'b11, exp_v[4:2], exp_v[4:2], exp_v[1], exp_v[0]});
                end
            end
            if (en_o) begin
                if (wr_q.size() == 0) check("wr_extra", 1, 0);
                else begin
                    exp_v = wr_q.pop_front();
                    check("wr", {rw_o, addr_o, col_mask, row_sel},
                          {1'b1, exp_v[11:8], exp_v[7:4], exp_v[1:0]});
                end
            end
            if (en_o && (en_i || en_w)) check("rd_wr_overlap", 1, 0);
            if (arr_clr) clr_cnt++;
            if (done) begin
                seen_done = 1'b1;
                check("done_cyc", cyc, total);
                check("done_busy", busy, 1);
            end
            prev_en_i = en_i;
            start = (noise != 0 && cyc == 3);
            if (start) mnt = noise;
            if (done && start_at_done) begin
                start = 1'b1;
                mnt = 12'h111;
            end
            @(negedge clk);
        end
        if (!seen_done) check("timeout", 0, 1);
        check("busy_fall", busy, 0);
        check("done_pulse", done, 0);
        check("rd_left", rd_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
        check("clr_cnt", clr_cnt, tiles);
        $display("job mnt=%03h tiles=%0d cycles=%0d checks=%0d errors=%0d",
                 job, tiles, total, checks, errors);
    endtask

    task automatic run_illegal(input logic [11:0] job);
        mnt = job;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_quiet", {busy, en_i, en_w, en_o, arr_clr}, 0);
        @(negedge clk);
        check("err_one_cycle", err, 0);
        check("err_idle", {busy, en_i, en_o}, 0);
        $display("illegal mnt=%03h checks=%0d errors=%0d", job, checks, errors);
    endtask

    initial begin
        logic [11:0] job;
        int fld;
        repeat (2) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", all_outs(), 0);

        run_job(12'h444, 12'h000, 0, 1'b0);
        run_job(12'h888, 12'h000, 0, 1'b0);
        run_job(12'h535, 12'h000, 0, 1'b0);
        run_illegal(12'h094);
        run_illegal(12'h404);
        run_job(12'h626, 12'h888, 0, 1'b0);
        run_job(12'h888, 12'h000, 4, 1'b0);
        run_job(12'h111, 12'h000, 0, 1'b1);
        run_job(12'h111, 12'h000, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            job = {4'($urandom_range(1, 8)), 4'($urandom_range(1, 8)), 4'($urandom_range(1, 8))};
            run_job(job, (i % 2 == 1) ? 12'h181 : 12'h000, 0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            job = {4'($urandom_range(1, 8)), 4'($urandom_range(1, 8)), 4'($urandom_range(1, 8))};
            fld = int'($urandom_range(0, 2));
            job[fld * 4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
            run_illegal(job);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
